// File: rtl/vector_acc_multi.sv
// Multi-lane vector accumulator: integrates acc_len vectors of VECTOR_LEN samples per lane
// with saturating add and emits the final vector of each integration with sticky overflow flags.
module vector_acc_multi #(
   parameter int NUM_CH        = 2,
   parameter int DIN_WIDTH     = 32,
   parameter int DOUT_WIDTH    = 64,
   parameter int VECTOR_LEN    = 64,
   parameter int SIGNED        = 0,
   parameter int ACC_LEN_WIDTH = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_n_i,
   input  logic                           new_acc_i,
   input  logic [ACC_LEN_WIDTH-1:0]       acc_len_i,
   input  logic [NUM_CH*DIN_WIDTH-1:0]    din_i,
   input  logic                           din_valid_i,
   output logic [NUM_CH*DOUT_WIDTH-1:0]   dout_o,
   output logic                           dout_valid_o,
   output logic [$clog2(VECTOR_LEN)-1:0]  dout_addr_o,
   output logic                           dout_last_o,
   output logic [NUM_CH-1:0]              ovf_o
);

   localparam int AW = $clog2(VECTOR_LEN);
   localparam logic [DOUT_WIDTH-1:0] SMAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
   localparam logic [DOUT_WIDTH-1:0] SMIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

   logic [AW-1:0]            idx_q, idx_d;
   logic [ACC_LEN_WIDTH-1:0] vcnt_q, vcnt_d, len_q, len_d, acc_len_eff_s;
   logic                     pend_q, pend_d, boundary_s, start_s;

   logic                         v1_q, first1_q, final1_q;
   logic [AW-1:0]                idx1_q;
   logic [NUM_CH*DIN_WIDTH-1:0]  din1_q;

   logic                         v2_q;
   logic [AW-1:0]                idx2_q;
   logic [NUM_CH*DOUT_WIDTH-1:0] sum2_q, sum_s;

   logic [NUM_CH-1:0] sat_s, ovf_new_s, ovf_acc_q, ovf_acc_d;

   logic [NUM_CH*DOUT_WIDTH-1:0] dout_q, dout_d;
   logic                         dout_valid_q, dout_valid_d;
   logic [AW-1:0]                dout_addr_q, dout_addr_d;
   logic                         dout_last_q, dout_last_d;
   logic [NUM_CH-1:0]            ovf_q, ovf_d;

   // Sample index, vector count and integration-start control.
   always_comb begin
      acc_len_eff_s = acc_len_i;
      idx_d         = idx_q;
      vcnt_d        = vcnt_q;
      len_d         = len_q;
      pend_d        = pend_q | new_acc_i;
      if (acc_len_i == {ACC_LEN_WIDTH{1'b0}}) begin
         acc_len_eff_s = ACC_LEN_WIDTH'(1);
      end else begin
         acc_len_eff_s = acc_len_i;
      end
      boundary_s = din_valid_i && (idx_q == {AW{1'b0}});
      start_s    = boundary_s && (pend_q || (vcnt_q >= len_q));
      if (din_valid_i) begin
         idx_d = idx_q + AW'(1);
      end else begin
         idx_d = idx_q;
      end
      // A restart request arriving on the start cycle itself survives to the next boundary.
      if (start_s) begin
         len_d  = acc_len_eff_s;
         vcnt_d = ACC_LEN_WIDTH'(1);
         pend_d = new_acc_i;
      end else if (boundary_s) begin
         vcnt_d = vcnt_q + ACC_LEN_WIDTH'(1);
      end else begin
         vcnt_d = vcnt_q;
      end
   end

   // Control state register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         idx_q  <= {AW{1'b0}};
         vcnt_q <= {ACC_LEN_WIDTH{1'b0}};
         len_q  <= ACC_LEN_WIDTH'(1);
         pend_q <= 1'b1;
      end else begin
         idx_q  <= idx_d;
         vcnt_q <= vcnt_d;
         len_q  <= len_d;
         pend_q <= pend_d;
      end
   end

   // S0 -> S1 and S1 -> S2 pipeline registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         v1_q     <= 1'b0;
         first1_q <= 1'b0;
         final1_q <= 1'b0;
         idx1_q   <= {AW{1'b0}};
         din1_q   <= {(NUM_CH*DIN_WIDTH){1'b0}};
         v2_q     <= 1'b0;
         idx2_q   <= {AW{1'b0}};
         sum2_q   <= {(NUM_CH*DOUT_WIDTH){1'b0}};
      end else begin
         v1_q     <= din_valid_i;
         first1_q <= (vcnt_d == ACC_LEN_WIDTH'(1));
         final1_q <= (vcnt_d == len_d);
         idx1_q   <= idx_q;
         din1_q   <= din_i;
         v2_q     <= v1_q;
         idx2_q   <= idx1_q;
         sum2_q   <= sum_s;
      end
   end

   for (genvar l = 0; l < NUM_CH; l++) begin : g_lane
      logic [DOUT_WIDTH-1:0] mem_q [VECTOR_LEN];
      logic [DOUT_WIDTH-1:0] rd_q, ext_s, lane_sum_s;
      logic [DOUT_WIDTH:0]   add_s;
      logic                  lane_sat_s;

      if (SIGNED != 0) begin : g_sx
         assign ext_s = DOUT_WIDTH'($signed(din1_q[l*DIN_WIDTH +: DIN_WIDTH]));
      end else begin : g_zx
         assign ext_s = DOUT_WIDTH'(din1_q[l*DIN_WIDTH +: DIN_WIDTH]);
      end

      // Saturating add of the stored partial sum and the new sample.
      always_comb begin
         add_s      = {1'b0, rd_q} + {1'b0, ext_s};
         lane_sum_s = add_s[DOUT_WIDTH-1:0];
         lane_sat_s = 1'b0;
         if (first1_q) begin
            lane_sum_s = ext_s;
         end else if (SIGNED != 0) begin
            if ((rd_q[DOUT_WIDTH-1] == ext_s[DOUT_WIDTH-1]) &&
                (add_s[DOUT_WIDTH-1] != rd_q[DOUT_WIDTH-1])) begin
               lane_sat_s = 1'b1;
               lane_sum_s = rd_q[DOUT_WIDTH-1] ? SMIN : SMAX;
            end else begin
               lane_sum_s = add_s[DOUT_WIDTH-1:0];
            end
         end else if (add_s[DOUT_WIDTH]) begin
            lane_sat_s = 1'b1;
            lane_sum_s = {DOUT_WIDTH{1'b1}};
         end else begin
            lane_sum_s = add_s[DOUT_WIDTH-1:0];
         end
      end

      assign sum_s[l*DOUT_WIDTH +: DOUT_WIDTH] = lane_sum_s;
      assign sat_s[l]                          = lane_sat_s;

      // Accumulator memory: read in S0, write back in S2.
      always_ff @(posedge clk_i) begin
         if (v2_q) begin
            mem_q[idx2_q] <= sum2_q[l*DOUT_WIDTH +: DOUT_WIDTH];
         end
         if (din_valid_i) begin
            rd_q <= mem_q[idx_q];
         end
      end
   end

   // Sticky overflow tracking and output word selection.
   always_comb begin
      ovf_new_s    = (first1_q ? {NUM_CH{1'b0}} : ovf_acc_q) | sat_s;
      ovf_acc_d    = ovf_acc_q;
      dout_valid_d = v1_q && final1_q;
      dout_d       = dout_q;
      dout_addr_d  = dout_addr_q;
      dout_last_d  = dout_last_q;
      ovf_d        = ovf_q;
      if (v1_q) begin
         ovf_acc_d = ovf_new_s;
      end else begin
         ovf_acc_d = ovf_acc_q;
      end
      if (dout_valid_d) begin
         dout_d      = sum_s;
         dout_addr_d = idx1_q;
         dout_last_d = (idx1_q == AW'(VECTOR_LEN-1));
         ovf_d       = ovf_new_s;
      end else begin
         dout_d      = dout_q;
         dout_addr_d = dout_addr_q;
         dout_last_d = dout_last_q;
         ovf_d       = ovf_q;
      end
   end

   // Output and overflow registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ovf_acc_q    <= {NUM_CH{1'b0}};
         dout_q       <= {(NUM_CH*DOUT_WIDTH){1'b0}};
         dout_valid_q <= 1'b0;
         dout_addr_q  <= {AW{1'b0}};
         dout_last_q  <= 1'b0;
         ovf_q        <= {NUM_CH{1'b0}};
      end else begin
         ovf_acc_q    <= ovf_acc_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         dout_addr_q  <= dout_addr_d;
         dout_last_q  <= dout_last_d;
         ovf_q        <= ovf_d;
      end
   end

   assign dout_o       = dout_q;
   assign dout_valid_o = dout_valid_q;
   assign dout_addr_o  = dout_addr_q;
   assign dout_last_o  = dout_last_q;
   assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_vector_acc_multi.sv
// Directed bench: an unsigned 2-lane 8-bit instance and a signed 1-lane 8->10-bit instance,
// expected words queued from hand-computed tables and matched against outputs on the falling edge.
module tb_vector_acc_multi;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        new_acc_a, din_valid_a, dout_valid_a, dout_last_a;
   logic [15:0] acc_len_a, din_a, dout_a;
   logic [2:0]  dout_addr_a;
   logic [1:0]  ovf_a;
   logic        new_acc_b, din_valid_b, dout_valid_b, dout_last_b;
   logic [15:0] acc_len_b;
   logic [7:0]  din_b;
   logic [9:0]  dout_b;
   logic [2:0]  dout_addr_b;
   logic [0:0]  ovf_b;

   vector_acc_multi #(.NUM_CH(2), .DIN_WIDTH(8), .DOUT_WIDTH(8), .VECTOR_LEN(8),
                      .SIGNED(0), .ACC_LEN_WIDTH(16)) u_dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .new_acc_i(new_acc_a), .acc_len_i(acc_len_a),
      .din_i(din_a), .din_valid_i(din_valid_a), .dout_o(dout_a), .dout_valid_o(dout_valid_a),
      .dout_addr_o(dout_addr_a), .dout_last_o(dout_last_a), .ovf_o(ovf_a));

   vector_acc_multi #(.NUM_CH(1), .DIN_WIDTH(8), .DOUT_WIDTH(10), .VECTOR_LEN(8),
                      .SIGNED(1), .ACC_LEN_WIDTH(16)) u_dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .new_acc_i(new_acc_b), .acc_len_i(acc_len_b),
      .din_i(din_b), .din_valid_i(din_valid_b), .dout_o(dout_b), .dout_valid_o(dout_valid_b),
      .dout_addr_o(dout_addr_b), .dout_last_o(dout_last_b), .ovf_o(ovf_b));

   typedef struct {
      int          cyc;
      logic [15:0] dout;
      logic [2:0]  addr;
      logic        last;
      logic [1:0]  ovf;
   } exp_t;

   typedef struct {
      int sel, len, nvec, first, period;
      int d0b, d0s, d1, e0b, e0s, e1, eovf;
   } row_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Output monitors: every valid word must match the oldest expected word, including its cycle.
   always @(negedge clk) begin
      if (dout_valid_a) begin
         if (qa.size() == 0) begin
            check("a_unexpected_valid", 64'd1, 64'd0);
         end else begin
            ea = qa.pop_front();
            check("a_latency", 64'(cyc), 64'(ea.cyc));
            check("a_dout", 64'(dout_a), 64'(ea.dout));
            check("a_addr", 64'(dout_addr_a), 64'(ea.addr));
            check("a_last", 64'(dout_last_a), 64'(ea.last));
            check("a_ovf", 64'(ovf_a), 64'(ea.ovf));
         end
      end
      if (dout_valid_b) begin
         if (qb.size() == 0) begin
            check("b_unexpected_valid", 64'd1, 64'd0);
         end else begin
            eb = qb.pop_front();
            check("b_latency", 64'(cyc), 64'(eb.cyc));
            check("b_dout", 64'(dout_b), 64'(eb.dout[9:0]));
            check("b_addr", 64'(dout_addr_b), 64'(eb.addr));
            check("b_last", 64'(dout_last_b), 64'(eb.last));
            check("b_ovf", 64'(ovf_b), 64'(eb.ovf[0]));
         end
      end
   end

   task automatic send_vec(input int sel, input int d0b, input int d0s, input int d1,
                           input bit fin, input int e0b, input int e0s, input int e1,
                           input int eovf, input int na_idx, input int gap_pct, input int nsamp);
      exp_t e;
      for (int i = 0; i < nsamp; i++) begin
         for (int g = 0; g < 3; g++) begin
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
               @(posedge clk); #1;
            end
         end
         if (sel == 0) begin
            din_a       = {8'(d1), 8'(d0b + d0s * i)};
            din_valid_a = 1'b1;
            new_acc_a   = (i == na_idx);
         end else begin
            din_b       = 8'(d0b + d0s * i);
            din_valid_b = 1'b1;
            new_acc_b   = (i == na_idx);
         end
         if (fin) begin
            e.cyc  = cyc + 2;
            e.dout = (sel == 0) ? {8'(e1), 8'(e0b + e0s * i)} : 16'(10'(e0b + e0s * i));
            e.addr = 3'(i);
            e.last = (i == 7);
            e.ovf  = 2'(eovf);
            if (sel == 0) qa.push_back(e);
            else          qb.push_back(e);
         end
         @(posedge clk); #1;
         din_valid_a = 1'b0;
         din_valid_b = 1'b0;
         new_acc_a   = 1'b0;
         new_acc_b   = 1'b0;
      end
   endtask

   row_t rows[7];
   bit   fin;

   initial begin
      rows[0] = '{0, 4, 8, 4, 4,    0, 1,  10,    0, 4,  40, 0};
      rows[1] = '{0, 0, 2, 1, 1,    5, 0,   5,    5, 0,   5, 0};
      rows[2] = '{0, 1, 2, 1, 1,    5, 0,   5,    5, 0,   5, 0};
      rows[3] = '{0, 2, 4, 2, 2,  200, 0, 200,  255, 0, 255, 3};
      rows[4] = '{1, 8, 8, 8, 8, -128, 0,   0, -512, 0,   0, 1};
      rows[5] = '{1, 8, 8, 8, 8,    1, 0,   0,    8, 0,   0, 0};
      rows[6] = '{1, 8, 8, 8, 8,  127, 0,   0,  511, 0,   0, 1};

      rst_n = 1'b0;
      new_acc_a = 1'b0; din_valid_a = 1'b0; din_a = 16'd0; acc_len_a = 16'd0;
      new_acc_b = 1'b0; din_valid_b = 1'b0; din_b = 8'd0;  acc_len_b = 16'd0;

      @(negedge clk);
      check("rst_a_valid", 64'(dout_valid_a), 64'd0);
      check("rst_a_dout", 64'(dout_a), 64'd0);
      check("rst_a_addr", 64'(dout_addr_a), 64'd0);
      check("rst_a_last", 64'(dout_last_a), 64'd0);
      check("rst_a_ovf", 64'(ovf_a), 64'd0);
      check("rst_b_valid", 64'(dout_valid_b), 64'd0);
      check("rst_b_dout", 64'(dout_b), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int r = 0; r < 7; r++) begin
         if (rows[r].sel == 0) acc_len_a = 16'(rows[r].len);
         else                  acc_len_b = 16'(rows[r].len);
         for (int k = 1; k <= rows[r].nvec; k++) begin
            fin = (k >= rows[r].first) && (((k - rows[r].first) % rows[r].period) == 0);
            send_vec(rows[r].sel, rows[r].d0b, rows[r].d0s, rows[r].d1, fin,
                     rows[r].e0b, rows[r].e0s, rows[r].e1, rows[r].eovf, -1, 0, 8);
         end
      end

      // new_acc mid-vector 2 discards the integration; acc_len change after start is ignored.
      acc_len_a = 16'd4;
      send_vec(0, 0, 1, 10, 1'b0, 0, 0, 0, 0, -1, 0, 8);
      send_vec(0, 0, 1, 10, 1'b0, 0, 0, 0, 0,  3, 0, 8);
      send_vec(0, 0, 1, 10, 1'b0, 0, 0, 0, 0, -1, 0, 8);
      acc_len_a = 16'd1;
      send_vec(0, 0, 1, 10, 1'b0, 0, 0, 0, 0, -1, 0, 8);
      send_vec(0, 0, 1, 10, 1'b0, 0, 0, 0, 0, -1, 0, 8);
      send_vec(0, 0, 1, 10, 1'b1, 0, 4, 40, 0, -1, 0, 8);
      send_vec(0, 0, 1, 10, 1'b1, 0, 1, 10, 0, -1, 0, 8);

      // new_acc on a boundary sample defers the restart; new_acc in a final vector keeps its output.
      acc_len_a = 16'd2;
      send_vec(0, 0, 1, 10, 1'b0, 0, 0, 0, 0,  0, 0, 8);
      send_vec(0, 0, 1, 10, 1'b0, 0, 0, 0, 0, -1, 0, 8);
      send_vec(0, 0, 1, 10, 1'b1, 0, 2, 20, 0, 5, 0, 8);
      send_vec(0, 0, 1, 10, 1'b0, 0, 0, 0, 0, -1, 0, 8);
      send_vec(0, 0, 1, 10, 1'b1, 0, 2, 20, 0, -1, 0, 8);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("a_idle_valid", 64'(dout_valid_a), 64'd0);
      check("a_hold_dout", 64'(dout_a), 64'h140E);
      @(posedge clk); #1;

      // Gapped input with a reset in the middle of the second vector.
      acc_len_a = 16'd3;
      send_vec(0, 1, 1, 7, 1'b0, 0, 0, 0, 0, -1, 50, 8);
      send_vec(0, 1, 1, 7, 1'b0, 0, 0, 0, 0, -1, 50, 4);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("midrst_a_valid", 64'(dout_valid_a), 64'd0);
      check("midrst_a_dout", 64'(dout_a), 64'd0);
      check("midrst_a_ovf", 64'(ovf_a), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      send_vec(0, 1, 1, 7, 1'b0, 0, 0, 0, 0, -1, 50, 8);
      send_vec(0, 1, 1, 7, 1'b0, 0, 0, 0, 0, -1, 50, 8);
      send_vec(0, 1, 1, 7, 1'b1, 3, 3, 21, 0, -1, 50, 8);

      repeat (6) @(posedge clk);
      @(negedge clk);
      check("a_missing_words", 64'(qa.size()), 64'd0);
      check("b_missing_words", 64'(qb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
